// File: rtl/uart_tx_serializer_if.sv
// rtl/uart_tx_serializer_if.sv - byte handshake bundle for uart_tx_serializer; parity_odd exists only with UART_TX_PARITY_EN
interface uart_tx_serializer_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
`ifdef UART_TX_PARITY_EN
  logic                 parity_odd;

  modport master (output tx_data, output tx_valid, output parity_odd, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input parity_odd, output tx_ready);
`else
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
`endif
endinterface

// File: rtl/uart_tx_serializer.sv
// rtl/uart_tx_serializer.sv - UART transmit serializer paced by baud_tick (start, LSB-first data, stop bits)
// Optional parity bit enabled by defining UART_TX_PARITY_EN.
module uart_tx_serializer #(
  parameter int DATA_BITS = 8,
  parameter int STOP_BITS = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                baud_tick,
  uart_tx_serializer_if.slave byte_if,
  output logic                tx,
  output logic                tx_busy
);

  localparam int BIT_W  = $clog2(DATA_BITS);
  localparam int STOP_W = $clog2(STOP_BITS + 1);

  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
  localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_SYNC   = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]           state_q,    state_d;
  logic [DATA_BITS-1:0] shift_q,    shift_d;
  logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
  logic [STOP_W-1:0]    stop_cnt_q, stop_cnt_d;
  logic                 tx_q,       tx_d;
  logic                 ready_q,    ready_d;
  logic                 busy_q,     busy_d;
`ifdef UART_TX_PARITY_EN
  logic                 parity_q,   parity_d;
`endif

  assign tx               = tx_q;
  assign tx_busy          = busy_q;
  assign byte_if.tx_ready = ready_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    ready_d    = ready_q;
    busy_d     = busy_q;
`ifdef UART_TX_PARITY_EN
    parity_d   = parity_q;
`endif

    case (state_q)
      S_IDLE: begin
        // baud_tick is deliberately ignored here; a coincident tick is not consumed
        tx_d    = 1'b1;
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (byte_if.tx_valid && ready_q) begin
          shift_d = byte_if.tx_data;
`ifdef UART_TX_PARITY_EN
          // the shift register is consumed bit by bit, so parity is fixed at acceptance
          parity_d = (^byte_if.tx_data) ^ byte_if.parity_odd;
`endif
          ready_d = 1'b0;
          busy_d  = 1'b1;
          state_d = S_SYNC;
        end
      end

      S_SYNC: begin
        if (baud_tick) begin
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

      S_START: begin
        if (baud_tick) begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = S_DATA;
        end
      end

      S_DATA: begin
        if (baud_tick) begin
          if (bit_cnt_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            tx_d    = parity_q;
            state_d = S_PARITY;
`else
            tx_d       = 1'b1;
            stop_cnt_d = '0;
            state_d    = S_STOP;
`endif
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (baud_tick) begin
          tx_d       = 1'b1;
          stop_cnt_d = '0;
          state_d    = S_STOP;
        end
      end
`endif

      S_STOP: begin
        tx_d = 1'b1;
        if (baud_tick) begin
          if (stop_cnt_q == STOP_LAST) begin
            busy_d  = 1'b0;
            ready_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            stop_cnt_d = stop_cnt_q + STOP_W'(1);
          end
        end
      end

      default: begin
        // unused encodings recover to an idle, ready line
        state_d    = S_IDLE;
        tx_d       = 1'b1;
        ready_d    = 1'b1;
        busy_d     = 1'b0;
        bit_cnt_d  = '0;
        stop_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= '0;
      tx_q       <= 1'b1;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
`ifdef UART_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
